router_term_src: RTL and testbench
==================================

Name: router_term_src

Overview:
- Per-terminal source stage directly upstream of router_bus_gnrtr, one instance per terminal.
- Accepts payload writes from the terminal-side client and builds full router packets by inserting destination and source headers.
- Buffers packets in a FIFO and presents them to the router's data_out_i_in/pndng_i_in/popin input handshake.
- Filters illegal destinations and counts dropped and rejected writes for the verification environment.

Parameters:
pckg_sz, 32, packet width in bits; must be >= 24.
fifo_depth, 16, packet entries; power of two, >= 2.
num_ntrfs, 4, number of router terminals; legal unicast destinations are 0..num_ntrfs-1.
term_id, 0, this terminal's ID, inserted as the source field.
broadcast, 8'hFF, destination ID meaning all terminals.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
push  in  1  client write strobe
push_dest  in  8  destination ID
push_payload  in  pckg_sz-16  payload
full  out  1  FIFO holds fifo_depth entries
count  out  $clog2(fifo_depth+1)  occupancy
drop_cnt  out  16  saturating count of pushes lost because the FIFO was full
rej_cnt  out  16  saturating count of pushes rejected for an illegal destination
underflow  out  1  sticky; popin seen while empty
data_out_i_in  out  pckg_sz  head packet to router
pndng_i_in  out  1  FIFO not empty
popin  in  1  router consumes head packet

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port clk, reset port reset. All state is sampled on posedge clk.
- Reset (reset==0 at posedge):
  - Pointers, count, drop_cnt, rej_cnt and underflow clear to 0.
  - pndng_i_in=0, full=0, data_out_i_in=0.
  - Reset takes priority over push/popin in the same cycle.
  - Entries in flight are discarded; stored RAM contents need not be cleared.
- Packet format: [pckg_sz-1:pckg_sz-8]=push_dest, [pckg_sz-9:pckg_sz-16]=term_id[7:0], [pckg_sz-17:0]=push_payload.
- Legal destination: push_dest < num_ntrfs, or push_dest == broadcast.
  - Self-addressed packets (push_dest == term_id) are legal.
  - push with an illegal destination: no write, rej_cnt+1 (saturates at 16'hFFFF). This check runs before the full check.
- Write: push, legal destination and not full -> packet written at wr_ptr, wr_ptr+1 (wraps modulo fifo_depth), count+1.
- push, legal destination and full:
  - If popin is also asserted, the write is accepted (the pop frees a slot the same cycle).
  - Otherwise no write and drop_cnt+1 (saturating).
- Read: popin && pndng_i_in -> rd_ptr+1 (wraps), count-1.
- popin while empty: ignored, underflow set to 1 and held until reset.
- Simultaneous valid push and pop: count unchanged, both pointers advance.
- Output timing: first-word fall-through.
  - data_out_i_in always equals mem[rd_ptr] while pndng_i_in=1; it is 0 when empty.
  - pndng_i_in = (count != 0), registered-state derived with no combinational path from push.
  - A push into an empty FIFO shows pndng_i_in=1 on the next cycle.
  - After popin on the last entry, pndng_i_in falls on the next cycle.
- Router handshake: the router samples data_out_i_in in the same cycle it asserts popin. The value must be stable across that cycle; the next head is valid the following cycle.
- full = (count == fifo_depth).
- No state machine beyond the pointer/count logic. The counters are the only saturating arithmetic. Pointers are $clog2(fifo_depth) bits and wrap naturally.

Decomposition:
- Shared package router_pkg:
  - ID_W=8, BROADCAST=8'hFF.
  - Header field offsets as functions of pckg_sz.
  - Packet typedef helper function mk_pkt(dest, src, payload).
  - The legality function is_legal_dest(dest, num_ntrfs).
- Sub-module router_fifo_core: generic synchronous FWFT FIFO with pointers, count, full, empty and underflow.
- router_term_src wraps router_fifo_core and adds header insertion, destination filtering and the drop/reject counters.

Test Plan:
All cases use pckg_sz=32, fifo_depth=16, num_ntrfs=4, term_id=2.
1. Reset, then push dest=1, payload=16'hABCD -> next cycle pndng_i_in=1, data_out_i_in=32'h0102ABCD, count=1. popin one cycle -> pndng_i_in=0, count=0.
2. Push dest=5 payload=16'h0001 -> rej_cnt=1, count=0, pndng_i_in=0. Push dest=8'hFF -> accepted, head=32'hFF020001.
3. 16 pushes (payloads 0..15) -> full=1, count=16. 17th push -> drop_cnt=1, head payload still 0. Push+popin while full -> accepted, count stays 16, tail payload is the new value.
4. Fill 16, pop 16, refill 5 -> pointers wrap. Popped order is payloads 0..15 then the new 5 in order, with no duplicates or gaps.
5. popin with FIFO empty -> underflow=1, count=0. underflow stays 1 through later traffic and clears only after reset=0.
6. Fill 10 entries, assert reset=0 for one cycle together with push and popin -> next cycle count=0, pndng_i_in=0, full=0, drop_cnt=0, rej_cnt=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: ID width, broadcast ID, header layout and the
// packet-build and destination-legality helpers used by the terminal stages.
package router_pkg;

  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 64;
  localparam int PAY_MAX_W = PKT_MAX_W - 2*ID_W;
  localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

  function automatic int dest_lsb(input int pckg_sz);
    return pckg_sz - ID_W;
  endfunction

  function automatic int src_lsb(input int pckg_sz);
    return pckg_sz - 2*ID_W;
  endfunction

  // Packet is {dest, src, payload} right-aligned in a PKT_MAX_W container;
  // the caller narrows it to its own pckg_sz.
  function automatic logic [PKT_MAX_W-1:0] mk_pkt(input logic [ID_W-1:0] dest,
                                                  input logic [ID_W-1:0] src,
                                                  input logic [PAY_MAX_W-1:0] payload,
                                                  input int pckg_sz);
    return (PKT_MAX_W'(dest) << dest_lsb(pckg_sz))
         | (PKT_MAX_W'(src)  << src_lsb(pckg_sz))
         | PKT_MAX_W'(payload);
  endfunction

  function automatic logic is_legal_dest(input logic [ID_W-1:0] dest, input int num_ntrfs);
    return (int'(dest) < num_ntrfs) || (dest == BROADCAST);
  endfunction

endpackage

// File: rtl/router_fifo_core.sv
// Synchronous first-word-fall-through FIFO; head is zero while empty and
// pops on an empty FIFO set a sticky underflow flag.
module router_fifo_core #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          underflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the write.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/router_term_src.sv
// Terminal source stage: wraps client payloads with dest/src headers, filters
// illegal destinations and queues packets for the router input handshake.
module router_term_src
  import router_pkg::*;
#(
  parameter int pckg_sz    = 32,
  parameter int fifo_depth = 16,
  parameter int num_ntrfs  = 4,
  parameter int term_id    = 0,
  parameter logic [7:0] broadcast = 8'hFF,
  localparam int CW = $clog2(fifo_depth+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [7:0]         push_dest,
  input  logic [pckg_sz-17:0] push_payload,
  output logic               full,
  output logic [CW-1:0]      count,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        rej_cnt,
  output logic               underflow,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin
);

  typedef logic [pckg_sz-1:0] pkt_t;

  logic legal, wr_req, empty;
  pkt_t pkt;

  // The package legality check knows BROADCAST; the local parameter may
  // override it, so both are honoured.
  assign legal  = is_legal_dest(push_dest, num_ntrfs) ||
                  ((push_dest == broadcast) && (broadcast != BROADCAST));
  assign wr_req = push && legal;
  assign pkt    = pkt_t'(mk_pkt(push_dest, ID_W'(term_id), PAY_MAX_W'(push_payload), pckg_sz));
  assign pndng_i_in = !empty;

  router_fifo_core #(.W(pckg_sz), .DEPTH(fifo_depth)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_req),
    .wr_data   (pkt),
    .rd_en     (popin),
    .rd_data   (data_out_i_in),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .underflow (underflow)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt <= '0;
      rej_cnt  <= '0;
    end else begin
      if (push && !legal && rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
      if (wr_req && full && !popin && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_router_term_src.sv
// Directed bench for router_term_src: vector table for single-cycle behaviour
// plus hand sequences for fill/drop, pointer wrap and reset during traffic.
module tb_router_term_src;

  logic        clk = 1'b0;
  logic        reset, push, popin;
  logic [7:0]  push_dest;
  logic [15:0] push_payload;
  logic        full, underflow, pndng_i_in;
  logic [4:0]  count;
  logic [15:0] drop_cnt, rej_cnt;
  logic [31:0] data_out_i_in;

  int checks = 0;
  int failures = 0;

  router_term_src #(.pckg_sz(32), .fifo_depth(16), .num_ntrfs(4), .term_id(2)) dut (
    .clk(clk), .reset(reset), .push(push), .push_dest(push_dest),
    .push_payload(push_payload), .full(full), .count(count),
    .drop_cnt(drop_cnt), .rej_cnt(rej_cnt), .underflow(underflow),
    .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, push, popin;
    logic [7:0]  dest;
    logic [15:0] payload;
    int          cnt;
    logic        pndng, full, uf;
    logic [31:0] data;
    int          drop, rej;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, sample 1 time unit after the rising edge.
  task automatic step(input logic rst_n, input logic p, input logic [7:0] d,
                      input logic [15:0] pl, input logic pop);
    reset = rst_n; push = p; push_dest = d; push_payload = pl; popin = pop;
    @(posedge clk);
    #1;
    reset = 1'b1; push = 1'b0; popin = 1'b0;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  initial begin
    //          rst push pop dest   payload   cnt pnd full uf  data          drop rej
    tbl[0]  = '{1'b0,1'b1,1'b1,8'h01,16'hAAAA, 0, 1'b0,1'b0,1'b0,32'h0,        0, 0};
    tbl[1]  = '{1'b1,1'b1,1'b0,8'h01,16'hABCD, 1, 1'b1,1'b0,1'b0,32'h0102ABCD, 0, 0};
    tbl[2]  = '{1'b1,1'b0,1'b0,8'h00,16'h0000, 1, 1'b1,1'b0,1'b0,32'h0102ABCD, 0, 0};
    tbl[3]  = '{1'b1,1'b0,1'b1,8'h00,16'h0000, 0, 1'b0,1'b0,1'b0,32'h0,        0, 0};
    tbl[4]  = '{1'b1,1'b1,1'b0,8'h05,16'h0001, 0, 1'b0,1'b0,1'b0,32'h0,        0, 1};
    tbl[5]  = '{1'b1,1'b1,1'b0,8'h04,16'h0002, 0, 1'b0,1'b0,1'b0,32'h0,        0, 2};
    tbl[6]  = '{1'b1,1'b1,1'b0,8'hFF,16'h0001, 1, 1'b1,1'b0,1'b0,32'hFF020001, 0, 2};
    tbl[7]  = '{1'b1,1'b1,1'b1,8'h02,16'h1234, 1, 1'b1,1'b0,1'b0,32'h02021234, 0, 2};
    tbl[8]  = '{1'b1,1'b0,1'b1,8'h00,16'h0000, 0, 1'b0,1'b0,1'b0,32'h0,        0, 2};
    tbl[9]  = '{1'b1,1'b0,1'b1,8'h00,16'h0000, 0, 1'b0,1'b0,1'b1,32'h0,        0, 2};
    tbl[10] = '{1'b1,1'b1,1'b1,8'h03,16'h0077, 1, 1'b1,1'b0,1'b1,32'h03020077, 0, 2};
    tbl[11] = '{1'b1,1'b0,1'b1,8'h00,16'h0000, 0, 1'b0,1'b0,1'b1,32'h0,        0, 2};
    tbl[12] = '{1'b1,1'b1,1'b0,8'h00,16'h0055, 1, 1'b1,1'b0,1'b1,32'h00020055, 0, 2};
    tbl[13] = '{1'b0,1'b0,1'b0,8'h00,16'h0000, 0, 1'b0,1'b0,1'b0,32'h0,        0, 0};

    reset = 1'b0; push = 1'b0; popin = 1'b0; push_dest = '0; push_payload = '0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst_n, tbl[i].push, tbl[i].dest, tbl[i].payload, tbl[i].popin);
      chk($sformatf("v%0d.count", i), 32'(count), tbl[i].cnt);
      chk($sformatf("v%0d.pndng", i), 32'(pndng_i_in), 32'(tbl[i].pndng));
      chk($sformatf("v%0d.full", i), 32'(full), 32'(tbl[i].full));
      chk($sformatf("v%0d.uf", i), 32'(underflow), 32'(tbl[i].uf));
      chk($sformatf("v%0d.data", i), data_out_i_in, tbl[i].data);
      chk($sformatf("v%0d.drop", i), 32'(drop_cnt), tbl[i].drop);
      chk($sformatf("v%0d.rej", i), 32'(rej_cnt), tbl[i].rej);
    end

    // Fill to full, drop on overflow, then push+pop while full.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'h00, 16'(i), 1'b0);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.count", 32'(count), 32'd16);
    chk("fill.head", data_out_i_in, 32'h00020000);
    step(1'b1, 1'b1, 8'h00, 16'h00EE, 1'b0);
    chk("ovf.drop", 32'(drop_cnt), 32'd1);
    chk("ovf.count", 32'(count), 32'd16);
    chk("ovf.head", data_out_i_in, 32'h00020000);
    step(1'b1, 1'b1, 8'h01, 16'h0099, 1'b1);
    chk("pp.count", 32'(count), 32'd16);
    chk("pp.drop", 32'(drop_cnt), 32'd1);
    chk("pp.head", data_out_i_in, 32'h00020001);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d", i), data_out_i_in, {16'h0002, 16'(i)});
      step(1'b1, 1'b0, 8'h00, 16'h0, 1'b1);
    end
    chk("tail.head", data_out_i_in, 32'h01020099);
    step(1'b1, 1'b0, 8'h00, 16'h0, 1'b1);
    chk("tail.empty", 32'(pndng_i_in), 32'd0);

    // Pointer wrap: reset, fill, drain, refill 5.
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'h03, 16'(i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wrapA%0d", i), data_out_i_in, {16'h0302, 16'(i)});
      step(1'b1, 1'b0, 8'h00, 16'h0, 1'b1);
    end
    chk("wrap.mid_count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h03, 16'(100 + i), 1'b0);
    chk("wrap.count5", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wrapB%0d", i), data_out_i_in, {16'h0302, 16'(100 + i)});
      step(1'b1, 1'b0, 8'h00, 16'h0, 1'b1);
    end
    chk("wrap.end_pndng", 32'(pndng_i_in), 32'd0);
    chk("wrap.uf", 32'(underflow), 32'd0);

    // Reset with traffic pending and counters nonzero.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'h01, 16'(i), 1'b0);
    step(1'b1, 1'b1, 8'h09, 16'h0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 16'h0, 1'b1);
    chk("pre_rst.count", 32'(count), 32'd9);
    chk("pre_rst.rej", 32'(rej_cnt), 32'd1);
    chk("pre_rst.uf", 32'(underflow), 32'd0);
    step(1'b0, 1'b1, 8'h01, 16'h4444, 1'b1);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.pndng", 32'(pndng_i_in), 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.drop", 32'(drop_cnt), 32'd0);
    chk("rst.rej", 32'(rej_cnt), 32'd0);
    chk("rst.data", data_out_i_in, 32'h0);
    idle();
    chk("post_rst.count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
